// File: rtl/aes_round_sequencer_if.sv
// Handshake bundle between the AES round sequencer and the round datapath / key schedule / core FSM.
// The master modport is the sequencer's view; slave is the view of whatever drives its inputs.
interface aes_round_sequencer_if #(
    parameter int ROUND_W = 4
);
    logic               start_i;
    logic               abort_i;
    logic               key_vld_i;
    logic               ark_done_i;
    logic               sb_done_i;
    logic               sr_done_i;
    logic               mc_done_i;
    logic               key_req_o;
    logic               ark_en_o;
    logic               sb_en_o;
    logic               sr_en_o;
    logic               mc_en_o;
    logic               mc_last_o;
    logic [ROUND_W-1:0] round_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    modport master (
        input  start_i, abort_i, key_vld_i,
        input  ark_done_i, sb_done_i, sr_done_i, mc_done_i,
        output key_req_o, ark_en_o, sb_en_o, sr_en_o, mc_en_o, mc_last_o,
        output round_o, busy_o, done_o, err_o
    );

    modport slave (
        output start_i, abort_i, key_vld_i,
        output ark_done_i, sb_done_i, sr_done_i, mc_done_i,
        input  key_req_o, ark_en_o, sb_en_o, sr_en_o, mc_en_o, mc_last_o,
        input  round_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: walks KEY/ARK/SB/SR/MC per round, issues one-cycle stage enables,
// waits for each stage's done, and aborts to IDLE with a sticky error if any wait runs too long.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS  = 10,
    parameter int ROUND_W     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    aes_round_sequencer_if.master bus
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_ARK,
        S_SB,
        S_SR,
        S_MC,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [WD_W-1:0]    wd_q,    wd_d;
    logic               first_q, first_d;
    logic               err_q,   err_d;

    logic waiting;
    logic advance;
    logic last_round;

    assign last_round = (round_q == LAST_ROUND);

    // first_q marks the issue cycle of a state: enables fire there and done inputs are not yet looked at.
    always_comb begin
        waiting = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            S_KEY: begin
                waiting = 1'b1;
                advance = bus.key_vld_i;
            end
            S_ARK: begin
                waiting = !first_q;
                advance = !first_q && bus.ark_done_i;
            end
            S_SB: begin
                waiting = !first_q;
                advance = !first_q && bus.sb_done_i;
            end
            S_SR: begin
                waiting = !first_q;
                advance = !first_q && bus.sr_done_i;
            end
            S_MC: begin
                waiting = !first_q;
                advance = !first_q && bus.mc_done_i;
            end
            default: ;
        endcase
    end

    // NOTE: every variable gets a default before the branches so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        err_d   = err_q;
        wd_d    = '0;

        if (bus.abort_i) begin
            state_d = S_IDLE;
            round_d = '0;
        end else if (state_q == S_IDLE) begin
            if (bus.start_i) begin
                state_d = S_KEY;
                round_d = '0;
                err_d   = 1'b0;
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (advance) begin
            unique case (state_q)
                S_KEY: state_d = S_ARK;
                S_SB:  state_d = S_SR;
                S_SR:  state_d = S_MC;
                S_MC:  state_d = S_KEY;
                S_ARK: begin
                    if (last_round) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SB;
                        round_d = round_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (waiting) begin
            if (wd_q == WD_LAST) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end

        first_d = (state_d != state_q);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so all flops sample together.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            round_q <= '0;
            wd_q    <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            wd_q    <= wd_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from the registers, so an asynchronous reset clears them immediately.
    assign bus.key_req_o = (state_q == S_KEY);
    assign bus.ark_en_o  = (state_q == S_ARK) && first_q;
    assign bus.sb_en_o   = (state_q == S_SB)  && first_q;
    assign bus.sr_en_o   = (state_q == S_SR)  && first_q;
    assign bus.mc_en_o   = (state_q == S_MC)  && first_q && !last_round;
    assign bus.mc_last_o = (state_q == S_MC)  && first_q &&  last_round;
    assign bus.round_o   = round_q;
    assign bus.busy_o    = (state_q != S_IDLE);
    assign bus.done_o    = (state_q == S_DONE);
    assign bus.err_o     = err_q;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: each run pushes its expected profile, an ideal
// stage/key responder drives the handshakes, and the observed profile is popped and compared.
module tb_aes_round_sequencer;
    localparam int NR = 10;
    localparam int RW = 4;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_i = ~clk_i;

    aes_round_sequencer_if #(.ROUND_W(RW)) bus ();

    aes_round_sequencer #(
        .NUM_ROUNDS (NR),
        .ROUND_W    (RW),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int done_cyc;
        int end_cyc;
        int ark;
        int sb;
        int sr;
        int mc;
        int mcl;
        int kreq;
        int err_end;
        int err_c1;
        int rnd_end;
        int multi;
    } prof_t;

    prof_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start_i    = 1'b0;
        bus.abort_i    = 1'b0;
        bus.key_vld_i  = 1'b0;
        bus.ark_done_i = 1'b0;
        bus.sb_done_i  = 1'b0;
        bus.sr_done_i  = 1'b0;
        bus.mc_done_i  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".key_req"}, 32'(bus.key_req_o), 0);
        check({tag, ".ark_en"},  32'(bus.ark_en_o),  0);
        check({tag, ".sb_en"},   32'(bus.sb_en_o),   0);
        check({tag, ".sr_en"},   32'(bus.sr_en_o),   0);
        check({tag, ".mc_en"},   32'(bus.mc_en_o),   0);
        check({tag, ".mc_last"}, 32'(bus.mc_last_o), 0);
        check({tag, ".round"},   32'(bus.round_o),   0);
        check({tag, ".busy"},    32'(bus.busy_o),    0);
        check({tag, ".done"},    32'(bus.done_o),    0);
    endtask

    function automatic prof_t mk(int done_cyc, int end_cyc, int ark, int sb, int sr, int mc,
                                 int mcl, int kreq, int err_end, int rnd_end);
        prof_t p;
        p.done_cyc = done_cyc;
        p.end_cyc  = end_cyc;
        p.ark      = ark;
        p.sb       = sb;
        p.sr       = sr;
        p.mc       = mc;
        p.mcl      = mcl;
        p.kreq     = kreq;
        p.err_end  = err_end;
        p.err_c1   = 0;
        p.rnd_end  = rnd_end;
        p.multi    = 0;
        return p;
    endfunction

    // Cycle 1 is the cycle right after the edge that samples start_i.
    task automatic run_seq(input string name, input int kd_round, input int kd_len,
                           input int drop_round, input int abort_cyc, input int restart_cyc,
                           input bit spur_mc, input int reset_cyc, output prof_t o);
        logic p_ark = 1'b0, p_sb = 1'b0, p_sr = 1'b0, p_mc = 1'b0;
        int   kd    = 0;
        bit   fin   = 1'b0;
        o = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            if (cyc == 1) o.err_c1 = int'(bus.err_o);
            o.ark  += int'(bus.ark_en_o);
            o.sb   += int'(bus.sb_en_o);
            o.sr   += int'(bus.sr_en_o);
            o.mc   += int'(bus.mc_en_o);
            o.mcl  += int'(bus.mc_last_o);
            o.kreq += int'(bus.key_req_o);
            if (int'(bus.ark_en_o) + int'(bus.sb_en_o) + int'(bus.sr_en_o) +
                int'(bus.mc_en_o) + int'(bus.mc_last_o) > 1) o.multi++;
            o.err_end = int'(bus.err_o);
            o.rnd_end = int'(bus.round_o);
            if (bus.done_o) begin
                o.done_cyc = cyc;
                o.end_cyc  = cyc;
                fin        = 1'b1;
            end else if (!bus.busy_o) begin
                o.end_cyc = cyc;
                fin       = 1'b1;
            end

            bus.ark_done_i = p_ark;
            bus.sb_done_i  = p_sb && (int'(bus.round_o) != drop_round);
            bus.sr_done_i  = p_sr;
            bus.mc_done_i  = p_mc || (spur_mc && p_sb);
            bus.key_vld_i  = 1'b1;
            if (bus.key_req_o && int'(bus.round_o) == kd_round && kd < kd_len) begin
                bus.key_vld_i = 1'b0;
                kd++;
            end
            bus.abort_i = (cyc == abort_cyc);
            bus.start_i = (cyc == restart_cyc);
            p_ark = bus.ark_en_o;
            p_sb  = bus.sb_en_o;
            p_sr  = bus.sr_en_o;
            p_mc  = bus.mc_en_o || bus.mc_last_o;

            if (cyc == reset_cyc) begin
                #2 rst_n = 1'b0;
                #1;
                check_idle_outputs({name, ".async_rst"});
                check({name, ".async_rst.err"}, 32'(bus.err_o), 0);
                o.end_cyc = cyc;
                o.rnd_end = int'(bus.round_o);
                o.err_end = int'(bus.err_o);
                fin       = 1'b1;
            end
            if (!fin) tick();
        end
        check({name, ".terminated"}, 32'(fin), 1);
        clear_inputs();
        if (!rst_n) begin
            tick();
            rst_n = 1'b1;
        end
        tick();
        tick();
    endtask

    task automatic score(input string name, input prof_t got);
        prof_t e;
        check({name, ".sb_nonempty"}, 32'(exp_q.size()), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({name, ".done_cyc"}, got.done_cyc, e.done_cyc);
        check({name, ".end_cyc"},  got.end_cyc,  e.end_cyc);
        check({name, ".ark_en"},   got.ark,      e.ark);
        check({name, ".sb_en"},    got.sb,       e.sb);
        check({name, ".sr_en"},    got.sr,       e.sr);
        check({name, ".mc_en"},    got.mc,       e.mc);
        check({name, ".mc_last"},  got.mcl,      e.mcl);
        check({name, ".key_req"},  got.kreq,     e.kreq);
        check({name, ".err_end"},  got.err_end,  e.err_end);
        check({name, ".err_c1"},   got.err_c1,   e.err_c1);
        check({name, ".round"},    got.rnd_end,  e.rnd_end);
        check({name, ".onehot"},   got.multi,    e.multi);
    endtask

    prof_t got;

    initial begin
        clear_inputs();
        #2;
        check_idle_outputs("reset_hold");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("post_reset");
        check("post_reset.err", 32'(bus.err_o), 0);

        exp_q.push_back(mk(94, 94, 11, 10, 10, 9, 1, 11, 0, 10));
        run_seq("nominal", -1, 0, -1, -1, -1, 1'b0, -1, got);
        score("nominal", got);

        exp_q.push_back(mk(97, 97, 11, 10, 10, 9, 1, 14, 0, 10));
        run_seq("key_delay", 5, 3, -1, -1, -1, 1'b0, -1, got);
        score("key_delay", got);

        exp_q.push_back(mk(0, 30, 2, 2, 1, 1, 0, 2, 1, 2));
        run_seq("sb_timeout", -1, 0, 2, -1, -1, 1'b0, -1, got);
        score("sb_timeout", got);

        exp_q.push_back(mk(94, 94, 11, 10, 10, 9, 1, 11, 0, 10));
        run_seq("err_clear", -1, 0, -1, -1, -1, 1'b0, -1, got);
        score("err_clear", got);

        exp_q.push_back(mk(0, 41, 5, 5, 4, 4, 0, 5, 0, 0));
        run_seq("abort", -1, 0, -1, 40, -1, 1'b0, -1, got);
        score("abort", got);
        check_idle_outputs("abort_idle");

        exp_q.push_back(mk(94, 94, 11, 10, 10, 9, 1, 11, 0, 10));
        run_seq("after_abort", -1, 0, -1, -1, -1, 1'b0, -1, got);
        score("after_abort", got);

        exp_q.push_back(mk(94, 94, 11, 10, 10, 9, 1, 11, 0, 10));
        run_seq("restart_spur", -1, 0, -1, -1, 50, 1'b1, -1, got);
        score("restart_spur", got);

        exp_q.push_back(mk(0, 60, 7, 7, 7, 6, 0, 7, 0, 0));
        run_seq("mid_reset", -1, 0, -1, -1, -1, 1'b0, 60, got);
        score("mid_reset", got);

        exp_q.push_back(mk(94, 94, 11, 10, 10, 9, 1, 11, 0, 10));
        run_seq("after_reset", -1, 0, -1, -1, -1, 1'b0, -1, got);
        score("after_reset", got);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
